// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the register-map write arbiter.
// Included by rr_pick and reg_wr_arbiter.
package reg_wr_pkg;

  localparam int GNT_W        = 2;
  localparam int FLAG_W       = 3;
  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_LOCK = 8;

  localparam int OVF   = 0;
  localparam int ZERO  = 1;
  localparam int CARRY = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward,
// wrapping modulo N, and returns the first valid requester.
module rr_pick
  import reg_wr_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]     valid,
  input  logic [GNT_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [GNT_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && valid[(int'(last) + k) % N]) begin
        any = 1'b1;
        onehot[(int'(last) + k) % N] = 1'b1;
        idx = GNT_W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the register-map write port, 1-cycle registered.
// Optional grant locking is built in when REG_WR_LOCK_EN is defined.
module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_flag_en,
  input  logic [NUM_REQ*3-1:0]      req_flags,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      overflow_flag,
  output logic                      zero_flag,
  output logic                      carry_flag,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      locked
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t          state;
  arb_state_t          state_nx;
  logic [GNT_W-1:0]    last_gnt;
  logic [GNT_W-1:0]    owner;
  logic [GNT_W-1:0]    gnt_idx;
  logic [GNT_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_REQ-1:0]  lock_req;
  logic [CNT_W-1:0]    lock_cnt;
  logic [FLAG_W-1:0]   gnt_flags;
  logic                pick_any;
  logic                xfer;

`ifdef REG_WR_LOCK_EN
  assign lock_req = req_lock;
`else
  // Without locking the FSM can never leave ARB.
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_req    = '0;
`endif

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .valid  (req_valid),
    .last   (last_gnt),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    gnt_idx   = pick_idx;
    xfer      = 1'b0;
    unique case (state)
      ARB: begin
        req_ready = pick_oh;
        xfer      = pick_any;
        if (pick_any && lock_req[pick_idx])
          state_nx = LOCKED;
      end
      LOCKED: begin
        gnt_idx            = owner;
        req_ready[owner]   = req_valid[owner];
        xfer               = req_valid[owner];
        if (!lock_req[owner] ||
            lock_cnt == CNT_W'(MAX_LOCK))
          state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  assign gnt_flags =
    req_flags[int'(gnt_idx)*FLAG_W +: FLAG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      owner    <= '0;
      lock_cnt <= '0;
      last_gnt <= GNT_W'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      if (state == ARB && state_nx == LOCKED) begin
        owner    <= pick_idx;
        lock_cnt <= CNT_W'(1);
      end else if (state == LOCKED) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      // Released owner drops to lowest priority.
      if (state == LOCKED && state_nx == ARB)
        last_gnt <= owner;
      else if (xfer)
        last_gnt <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      grant_id      <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        wr_data  <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        grant_id <= gnt_idx;
      end
      if (xfer && req_flag_en[gnt_idx]) begin
        overflow_flag <= gnt_flags[OVF];
        zero_flag     <= gnt_flags[ZERO];
        carry_flag    <= gnt_flags[CARRY];
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
